seg_scan_mux: RTL and testbench

Parametrised N-digit time-multiplexed 7-segment scan controller. It is the successor to the 2-digit display mux: a generic digit count, a configurable dwell and blanking interval, 16-level PWM brightness and a per-digit blank mask. It also uses tear-free double-buffered digit loading, committed only at frame boundaries. It sits between the datapath (digit sources) and the hex-to-segment decoder plus the digit-enable transistor drivers.

---
 rtl/seg_pkg.sv | 10 +
 rtl/seg_pwm_window.sv | 32 +++
 rtl/seg_scan_mux.sv | 116 +++++++++++
 tb/tb_seg_scan_mux.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg_pkg;

  localparam int unsigned DIGIT_W_DEFAULT = 4;
  localparam int unsigned BRIGHT_W        = 4;
  localparam int unsigned PWM_STEPS       = 16;

  typedef logic [DIGIT_W_DEFAULT-1:0] digit_t;

endpackage : seg_pkg

// File: rtl/seg_pwm_window.sv
// Brightness window: flags the part of a slot where the digit enable may be on.
module seg_pwm_window
  import seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic [CNT_W-1:0]    cnt_i,
  input  logic [BRIGHT_W-1:0] bright_i,
  output logic                in_win_o
);

  localparam int unsigned ACTIVE  = DWELL_CYCLES - BLANK_CYCLES;
  localparam int unsigned ON_STEP = ACTIVE / PWM_STEPS;

  int unsigned win;
  int unsigned cnt_ext;

  // Full brightness covers the whole active span so the division remainder is not lost.
  always_comb begin
    win      = '0;
    cnt_ext  = 32'(cnt_i);
    if (bright_i == BRIGHT_W'(PWM_STEPS - 1)) begin
      win = ACTIVE;
    end else begin
      win = ON_STEP * (32'(bright_i) + 32'd1);
    end
    in_win_o = (cnt_ext >= BLANK_CYCLES) && ((cnt_ext - BLANK_CYCLES) < win);
  end

endmodule : seg_pwm_window

// File: rtl/seg_scan_mux.sv
// N-digit time-multiplexed 7-segment scan controller with PWM dimming,
// per-digit blanking and frame-synchronous double-buffered digit loading.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 100_000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned DIGIT_W      = DIGIT_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  input  logic                          load,
  input  logic [NUM_DIGITS-1:0]         blankMask,
  input  logic [BRIGHT_W-1:0]           brightness,
  output logic [NUM_DIGITS-1:0]         onSeg,
  output logic [DIGIT_W-1:0]            sevenSegIn,
  output logic                          frameDone
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam int unsigned IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BUF_W = NUM_DIGITS * DIGIT_W;

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 ||
      BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_param_check
    $error("seg_scan_mux: illegal NUM_DIGITS/BLANK_CYCLES/DWELL_CYCLES combination");
  end

  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic [IDX_W-1:0]    idx_q,     idx_d;
  logic [BUF_W-1:0]    staging_q, staging_d;
  logic [BUF_W-1:0]    shadow_q,  shadow_d;
  logic                pending_q, pending_d;
  logic [BRIGHT_W-1:0] bright_q,  bright_d;
  logic                frame_q,   frame_d;
  logic                last_slot;
  logic                boundary;
  logic                in_win;

  always_comb begin
    last_slot = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    boundary  = last_slot && (idx_q == IDX_W'(NUM_DIGITS - 1));

    cnt_d = last_slot ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (last_slot) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    staging_d = load ? digits : staging_q;
    pending_d = pending_q | load;
    shadow_d  = shadow_q;
    bright_d  = bright_q;

    // A load coinciding with the boundary bypasses staging so it is not delayed a frame.
    if (boundary) begin
      bright_d = brightness;
      if (load) begin
        shadow_d  = digits;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staging_q;
        pending_d = 1'b0;
      end
    end

    // Registered pulse: asserted when the next state is the frame's final cycle.
    frame_d = (cnt_d == CNT_W'(DWELL_CYCLES - 1)) && (idx_d == IDX_W'(NUM_DIGITS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      bright_q  <= '1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      bright_q  <= bright_d;
      frame_q   <= frame_d;
    end
  end

  seg_pwm_window #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_pwm (
    .cnt_i    (cnt_q),
    .bright_i (bright_q),
    .in_win_o (in_win)
  );

  always_comb begin
    sevenSegIn = '0;
    onSeg      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sevenSegIn = shadow_q[i*DIGIT_W +: DIGIT_W];
        onSeg[i]   = in_win && !blankMask[i];
      end
    end
  end

  assign frameDone = frame_q;

endmodule : seg_scan_mux

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: 3 digits, 20-cycle slots, 4-cycle blank, 60-cycle frame.
module tb_seg_scan_mux;
  import seg_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] on;
    logic [3:0] seg;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] digits = '0;
  logic        load = 1'b0;
  logic [2:0]  blankMask = '0;
  logic [3:0]  brightness = 4'd15;
  logic [2:0]  onSeg;
  digit_t      sevenSegIn;
  logic        frameDone;

  int compared = 0;
  int mismatched = 0;
  exp_t sb[$];

  seg_scan_mux #(
    .NUM_DIGITS   (3),
    .DWELL_CYCLES (20),
    .BLANK_CYCLES (4),
    .DIGIT_W      (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .load       (load),
    .blankMask  (blankMask),
    .brightness (brightness),
    .onSeg      (onSeg),
    .sevenSegIn (sevenSegIn),
    .frameDone  (frameDone)
  );

  always #5 clk = ~clk;

  // Expected outputs at cycle t after reset release for a given shadow, brightness and mask.
  function automatic exp_t model(int t, logic [11:0] sh, int br, logic [2:0] mask);
    exp_t e;
    int cnt = t % 20;
    int idx = (t / 20) % 3;
    int win = (br == 15) ? 16 : br + 1;
    e.cyc = t;
    e.on  = '0;
    if (cnt >= 4 && (cnt - 4) < win && !mask[idx]) e.on[idx] = 1'b1;
    e.seg = sh[idx*4 +: 4];
    e.fd  = (idx == 2 && cnt == 19);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      compared++;
      if ($countones(onSeg) > 1) begin
        mismatched++;
        $display("FAIL onehot t=%0t onSeg=%b required at most one bit set", $time, onSeg);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; digits = '0; blankMask = '0; brightness = 4'd15;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    sb.push_back('{cyc: -1, on: 3'b000, seg: 4'h0, fd: 1'b0});
    @(posedge clk); #1;
    begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL reset_onSeg got=%b exp=%b", onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL reset_seg got=%h exp=%h", sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL reset_frameDone got=%b exp=%b", frameDone, e.fd); end
    end
  endtask

  task automatic test_scan();
    do_reset();
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t < 125; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL scan_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL scan_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL scan_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      sb.push_back(model(t + 1, '0, 15, '0));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    do_reset();
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t < 125; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL load_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL load_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL load_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      load = (t == 10);
      digits = (t == 10) ? {4'hC, 4'h9, 4'h5} : 12'h000;
      sb.push_back(model(t + 1, (t + 1 >= 60) ? 12'hC95 : 12'h000, 15, '0));
      @(posedge clk); #1;
    end
    load = 1'b0;
  endtask

  task automatic test_brightness();
    do_reset();
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t < 125; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL bright_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL bright_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL bright_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      if (t == 30) brightness = 4'd3;
      sb.push_back(model(t + 1, '0, (t + 1 >= 60) ? 3 : 15, '0));
      @(posedge clk); #1;
    end
  endtask

  task automatic test_blank_mask();
    do_reset();
    blankMask = 3'b010;
    sb.push_back(model(0, '0, 15, 3'b010));
    for (int t = 0; t < 125; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL mask_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL mask_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL mask_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      load = (t == 0);
      digits = (t == 0) ? 12'hAB7 : 12'h000;
      sb.push_back(model(t + 1, (t + 1 >= 60) ? 12'hAB7 : 12'h000, 15, 3'b010));
      @(posedge clk); #1;
    end
    load = 1'b0;
    blankMask = '0;
  endtask

  task automatic test_back_to_back();
    // Case A: load on the boundary cycle itself, then a quiet boundary must keep it.
    do_reset();
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t < 125; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL bypass_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL bypass_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL bypass_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      load = (t == 59);
      digits = (t == 59) ? {4'h1, 4'h2, 4'h3} : 12'hFFF;
      sb.push_back(model(t + 1, (t + 1 >= 60) ? 12'h123 : 12'h000, 15, '0));
      @(posedge clk); #1;
    end
    load = 1'b0;
    // Case B: two loads in one frame; only the later one is committed.
    do_reset();
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t < 85; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL lastwins_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL lastwins_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL lastwins_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      load = (t == 20) || (t == 40);
      digits = (t == 20) ? 12'h456 : (t == 40) ? 12'h789 : 12'h000;
      sb.push_back(model(t + 1, (t + 1 >= 60) ? 12'h789 : 12'h000, 15, '0));
      @(posedge clk); #1;
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t <= 107; t++) begin
      exp_t e = sb.pop_front();
      compared += 2;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL premid_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL premid_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      load = (t == 5);
      digits = (t == 5) ? 12'hE1D : 12'h000;
      if (t < 107) begin
        sb.push_back(model(t + 1, (t + 1 >= 60) ? 12'hE1D : 12'h000, 15, '0));
        @(posedge clk); #1;
      end
    end
    load = 1'b0;
    #2 reset = 1'b1;
    sb.push_back('{cyc: -1, on: 3'b000, seg: 4'h0, fd: 1'b0});
    #1;
    begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL midreset_onSeg got=%b exp=%b", onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL midreset_seg got=%h exp=%h", sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL midreset_frameDone got=%b exp=%b", frameDone, e.fd); end
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb.push_back(model(0, '0, 15, '0));
    for (int t = 0; t < 65; t++) begin
      exp_t e = sb.pop_front();
      compared += 3;
      if (onSeg !== e.on) begin mismatched++; $display("FAIL postmid_onSeg t=%0d got=%b exp=%b", e.cyc, onSeg, e.on); end
      if (sevenSegIn !== e.seg) begin mismatched++; $display("FAIL postmid_seg t=%0d got=%h exp=%h", e.cyc, sevenSegIn, e.seg); end
      if (frameDone !== e.fd) begin mismatched++; $display("FAIL postmid_frameDone t=%0d got=%b exp=%b", e.cyc, frameDone, e.fd); end
      sb.push_back(model(t + 1, '0, 15, '0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached before completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_brightness();
    test_blank_mask();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_seg_scan_mux
